// File: rtl/pulse_synchronizer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pulse_synchronizer_pkg
// Description : Shared limits and helpers for the pulse synchronizer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_synchronizer_pkg;

    localparam int c_SYNC_STAGES_MIN = 2;
    localparam int c_SYNC_STAGES_MAX = 4;
    localparam int c_MIN_HIGH_MIN    = 1;
    localparam int c_MIN_HIGH_MAX    = 15;
    localparam int c_CNT_WIDTH_MIN   = 1;

    // Wide enough to hold c_MIN_HIGH_MAX.
    localparam int c_RUN_WIDTH       = 4;

    function automatic bit in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage : pulse_synchronizer_pkg
`default_nettype wire

// File: rtl/sync_ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : N-stage single-bit synchronizer, async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff
    import pulse_synchronizer_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    if (!in_range(STAGES, c_SYNC_STAGES_MIN, c_SYNC_STAGES_MAX)) begin : g_bad_stages
        $error("sync_ff: STAGES=%0d outside %0d..%0d",
               STAGES, c_SYNC_STAGES_MIN, c_SYNC_STAGES_MAX);
    end

    // Pure flop chain: nothing between stages so each stage gets a full
    // period to resolve.
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/pulse_synchronizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pulse_synchronizer
// Description : Converts rising edges of an async level into one-cycle
//               strobes, with high-level glitch filter and event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_synchronizer
    import pulse_synchronizer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 1,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 dst_clk,
    input  logic                 dst_rst_n,
    input  logic                 src_pulse,
    input  logic                 cnt_clr,
    output logic                 dst_pulse,
    output logic                 dst_level,
    output logic [CNT_WIDTH-1:0] dst_pulse_cnt
);

    if (!in_range(SYNC_STAGES, c_SYNC_STAGES_MIN, c_SYNC_STAGES_MAX)) begin : g_bad_sync_stages
        $error("pulse_synchronizer: SYNC_STAGES=%0d outside %0d..%0d",
               SYNC_STAGES, c_SYNC_STAGES_MIN, c_SYNC_STAGES_MAX);
    end
    if (!in_range(MIN_HIGH, c_MIN_HIGH_MIN, c_MIN_HIGH_MAX)) begin : g_bad_min_high
        $error("pulse_synchronizer: MIN_HIGH=%0d outside %0d..%0d",
               MIN_HIGH, c_MIN_HIGH_MIN, c_MIN_HIGH_MAX);
    end
    if (CNT_WIDTH < c_CNT_WIDTH_MIN) begin : g_bad_cnt_width
        $error("pulse_synchronizer: CNT_WIDTH=%0d must be >= %0d",
               CNT_WIDTH, c_CNT_WIDTH_MIN);
    end

    localparam logic [c_RUN_WIDTH-1:0] c_RUN_SAT    = c_RUN_WIDTH'(MIN_HIGH);
    localparam logic [c_RUN_WIDTH-1:0] c_RUN_ACCEPT = c_RUN_WIDTH'(MIN_HIGH - 1);

    logic                   w_level;
    logic                   w_accept;
    logic [c_RUN_WIDTH-1:0] r_run;
    logic                   r_pulse;
    logic [CNT_WIDTH-1:0]   r_cnt;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_ff (
        .clk   (dst_clk),
        .rst_n (dst_rst_n),
        .i_d   (src_pulse),
        .o_q   (w_level)
    );

    // Acceptance fires in the cycle the run counter is about to reach
    // MIN_HIGH; once saturated it cannot fire again until the level drops.
    assign w_accept = w_level && (r_run == c_RUN_ACCEPT);

    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            r_run <= '0;
        end else if (!w_level) begin
            r_run <= '0;
        end else if (r_run != c_RUN_SAT) begin
            r_run <= r_run + c_RUN_WIDTH'(1);
        end
    end

    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_accept;
        end
    end

    // Clear wins over a coincident increment.
    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (r_pulse && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign dst_pulse     = r_pulse;
    assign dst_level     = w_level;
    assign dst_pulse_cnt = r_cnt;

endmodule : pulse_synchronizer
`default_nettype wire

// File: tb/tb_pulse_synchronizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pulse_synchronizer
// Description : Directed self-checking bench for pulse_synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_synchronizer;

    logic dst_clk = 1'b0;
    always #3.5 dst_clk = ~dst_clk;

    logic       rst_n;
    logic       src_a, src_b, src_c;
    logic       clr_a, clr_b, clr_c;
    logic       pulse_a, pulse_b, pulse_c;
    logic       level_a, level_b, level_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    // Defaults
    pulse_synchronizer u_dut_a (
        .dst_clk (dst_clk), .dst_rst_n (rst_n), .src_pulse (src_a), .cnt_clr (clr_a),
        .dst_pulse (pulse_a), .dst_level (level_a), .dst_pulse_cnt (cnt_a)
    );

    // Glitch filter
    pulse_synchronizer #(.SYNC_STAGES (2), .MIN_HIGH (3), .CNT_WIDTH (8)) u_dut_b (
        .dst_clk (dst_clk), .dst_rst_n (rst_n), .src_pulse (src_b), .cnt_clr (clr_b),
        .dst_pulse (pulse_b), .dst_level (level_b), .dst_pulse_cnt (cnt_b)
    );

    // Narrow saturating counter
    pulse_synchronizer #(.SYNC_STAGES (2), .MIN_HIGH (1), .CNT_WIDTH (2)) u_dut_c (
        .dst_clk (dst_clk), .dst_rst_n (rst_n), .src_pulse (src_c), .cnt_clr (clr_c),
        .dst_pulse (pulse_c), .dst_level (level_c), .dst_pulse_cnt (cnt_c)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   pcnt_a = 0, pcnt_b = 0, pcnt_c = 0;
    int   wide_a = 0, wide_b = 0, wide_c = 0;
    logic prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0;

    // Strobe counters, sampled on the falling edge.
    always @(negedge dst_clk) begin
        if (pulse_a) pcnt_a++;
        if (pulse_b) pcnt_b++;
        if (pulse_c) pcnt_c++;
        if (pulse_a && prev_a) wide_a++;
        if (pulse_b && prev_b) wide_b++;
        if (pulse_c && prev_c) wide_c++;
        prev_a = pulse_a;
        prev_b = pulse_b;
        prev_c = pulse_c;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int lat;
        bit found;

        rst_n = 1'b0;
        src_a = 1'b0; src_b = 1'b0; src_c = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        repeat (3) @(posedge dst_clk);
        #1;
        check("rst_pulse",   pulse_a, 0);
        check("rst_level",   level_a, 0);
        check("rst_cnt",     cnt_a,   0);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge dst_clk);
        #1;
        check("idle_pulse", pulse_a, 0);

        // ---------------- single 10 ns pulse ----------------
        base = pcnt_a;
        @(posedge dst_clk);
        #2 src_a = 1'b1;
        fork begin #10 src_a = 1'b0; end join_none
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge dst_clk);
            #1;
            if (pulse_a && lat < 0) lat = k;
        end
        check("single_latency", lat, 2);
        check("single_count",   pcnt_a - base, 1);
        check("single_width",   wide_a, 0);
        check("single_cnt",     cnt_a, 1);

        // ---------------- clear, then three pulses ----------------
        clr_a = 1'b1;
        @(posedge dst_clk);
        #1 clr_a = 1'b0;
        check("clr_cnt", cnt_a, 0);
        base = pcnt_a;
        src_a = 1'b1; #10 src_a = 1'b0;
        #50 src_a = 1'b1; #10 src_a = 1'b0;
        #40 src_a = 1'b1; #10 src_a = 1'b0;
        repeat (8) @(posedge dst_clk);
        #1;
        check("three_count", pcnt_a - base, 3);
        check("three_cnt",   cnt_a, 3);
        check("three_width", wide_a, 0);

        // ---------------- long high ----------------
        base = pcnt_a;
        @(posedge dst_clk);
        #1 src_a = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge dst_clk);
            #1;
            if (k == 0)  check("long_level_e0",  level_a, 0);
            if (k == 5)  check("long_level_e5",  level_a, 1);
            if (k == 49) check("long_level_e49", level_a, 1);
        end
        src_a = 1'b0;
        repeat (2) @(posedge dst_clk);
        #1;
        check("long_level_low", level_a, 0);
        check("long_count",     pcnt_a - base, 1);
        check("long_cnt",       cnt_a, 4);

        // ---------------- glitch filter, MIN_HIGH=3 ----------------
        @(posedge dst_clk);
        #2 src_b = 1'b1;
        #14 src_b = 1'b0;
        repeat (8) @(posedge dst_clk);
        #1;
        check("filt_short_count", pcnt_b, 0);
        check("filt_short_cnt",   cnt_b,  0);

        @(posedge dst_clk);
        #2 src_b = 1'b1;
        fork begin #28 src_b = 1'b0; end join_none
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge dst_clk);
            #1;
            if (pulse_b && lat < 0) lat = k;
        end
        check("filt_latency", lat, 4);
        check("filt_count",   pcnt_b, 1);
        check("filt_cnt",     cnt_b, 1);

        // Exactly MIN_HIGH synchronized cycles is accepted.
        @(posedge dst_clk);
        #2 src_b = 1'b1;
        #21 src_b = 1'b0;
        repeat (8) @(posedge dst_clk);
        #1;
        check("filt_edge_count", pcnt_b, 2);
        check("filt_edge_cnt",   cnt_b, 2);
        check("filt_width",      wide_b, 0);

        // ---------------- saturating 2-bit counter ----------------
        for (int i = 0; i < 5; i++) begin
            @(posedge dst_clk);
            #2 src_c = 1'b1;
            #14 src_c = 1'b0;
            repeat (4) @(posedge dst_clk);
            #1;
            check("sat_cnt", cnt_c, (i + 1 > 3) ? 3 : i + 1);
        end
        check("sat_count", pcnt_c, 5);

        // cnt_clr in the same cycle as a strobe.
        @(posedge dst_clk);
        #2 src_c = 1'b1;
        fork begin #14 src_c = 1'b0; end join_none
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge dst_clk);
            #1;
            if (pulse_c) found = 1'b1;
        end
        check("clr_pulse_seen", found, 1);
        clr_c = 1'b1;
        @(posedge dst_clk);
        #1 clr_c = 1'b0;
        check("clr_coincide_cnt", cnt_c, 0);
        repeat (4) @(posedge dst_clk);
        #1;
        check("clr_hold_cnt", cnt_c, 0);

        // ---------------- async reset during a strobe ----------------
        @(posedge dst_clk);
        #2 src_a = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge dst_clk);
            #1;
            if (pulse_a) found = 1'b1;
        end
        check("rst_pulse_seen", found, 1);
        base = pcnt_a;
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_pulse", pulse_a, 0);
        check("rst_mid_level", level_a, 0);
        check("rst_mid_cnt",   cnt_a,   0);
        repeat (2) @(posedge dst_clk);
        #2 rst_n = 1'b1;
        repeat (8) @(posedge dst_clk);
        #1;
        check("rst_new_count", pcnt_a - base, 1);
        check("rst_new_cnt",   cnt_a, 1);
        check("rst_new_level", level_a, 1);
        src_a = 1'b0;
        repeat (3) @(posedge dst_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pulse_synchronizer
`default_nettype wire
